branch_resolve_unit: RTL
========================

# branch_resolve_unit

- ID-stage control-flow resolver: the requester side of the branch comparator.
- Decodes the control-flow instruction held in IF/ID and drives `CompCont` to the comparator. It samples the returned `ZeroFlag` in the same cycle and owns the fetch PC register.
- On a taken branch or any jump it redirects the PC and squashes IF/ID.
- It also handles JAL link generation, JR alignment checking and branch statistics counters.

## Interface
- PC_RESET, 32'h0000_0000, PC value loaded on reset
- Clk  in  1  system clock, rising edge
- Reset  in  1  asynchronous, active-high; clears all state immediately
- Stall  in  1  hazard hold from hazard unit; freezes PC, state, counters
- ValidID  in  1  IF/ID holds a real instruction
- Opcode  in  6  instr[31:26] of ID instruction
- Funct  in  6  instr[5:0]
- RtField  in  5  instr[20:16] (REGIMM select)
- Imm16  in  16  instr[15:0]
- JumpTarget  in  26  instr[25:0]
- PCPlus4ID  in  32  PC+4 of ID instruction
- RSData  in  32  forwarded rs value (JR target)
- ZeroFlag  in  1  comparator result for current `CompCont`
- CompCont  out  3  comparator operation select
- PC  out  32  fetch PC register
- Flush  out  1  squash IF/ID at next edge
- LinkWrite  out  1  write `LinkAddr` to $31 (JAL)
- LinkAddr  out  32  return address
- AddrErr  out  1  sticky: unaligned JR target seen
- BranchCount  out  32  resolved conditional branches
- TakenCount  out  32  taken conditional branches

## Operation
- **Decode.** Decode is active only when state=RUN and ValidID=1; otherwise the instruction decodes as non-control.
- **CompCont encoding:**
  - BGEZ (Opcode 000001, Rt 00001) = 000
  - BEQ (000100) = 001
  - BNE (000101) = 010
  - BGTZ (000111) = 011
  - BLEZ (000110) = 100
  - BLTZ (000001, Rt 00000) = 101
  - J (000010), JAL (000011), JR (Opcode 000000, Funct 001000) = 110
  - everything else = 111
- **Taken.** Taken = (CompCont != 111) && ZeroFlag && !Stall. The comparator returns 0 for 111 and 1 for 110.
- **Branch target.** PCPlus4ID + ({{14{Imm16[15]}}, Imm16, 2'b00}), computed modulo 2^32 (wraps, no error).
- **J/JAL target.** {PCPlus4ID[31:28], JumpTarget, 2'b00}.
- **JR target.** {RSData[31:2], 2'b00}. If RSData[1:0] != 0 on a taken JR, set AddrErr, which is sticky until Reset.
- **Next-PC priority:** Reset > Stall (hold) > Taken (target) > PC+4.
- **Flush.** Flush = Taken (combinational). No delay slot.
- **Link.** LinkWrite = Taken && JAL. LinkAddr = PCPlus4ID whenever the ID instruction is JAL, else 0.
- **Counters.**
  - BranchCount increments on each non-stalled conditional branch (CompCont 000–101).
  - TakenCount increments when that branch is also taken.
  - Both wrap 2^32-1 → 0. Jumps are not counted.
- **State machine, two states:**
  - RUN: decode as above. On Taken → REDIRECT.
  - REDIRECT: ID content is the flushed bubble and is ignored regardless of ValidID. CompCont=111, Flush=0, LinkWrite=0. PC advances +4 unless Stall. If !Stall → RUN; if Stall, stay.
- **Stall in RUN.** Stall holds the ID instruction. It re-resolves with fresh `ZeroFlag` when Stall drops, and no outputs with side effects are asserted while Stall=1.

## Timing
- **Reset values:** PC=PC_RESET, state=RUN, BranchCount=0, TakenCount=0, AddrErr=0. During Reset, Flush=0, LinkWrite=0, CompCont=111, LinkAddr=0.
- **Reset mid-redirect** returns to RUN with PC=PC_RESET; the pending target is discarded.
- **Resolution latency** is zero cycles: `CompCont` is out and `ZeroFlag` comes back in the same cycle. PC takes the target at the next rising edge.
- **Taken-branch penalty** is one bubble: the REDIRECT cycle.
- **Back-to-back control instructions:** the second one is always in REDIRECT and is ignored, since it is the squashed slot.
- **Stall and taken in the same cycle:** Stall wins; no redirect, no count, no link.
- **All registers** update on the Clk rising edge only.

## Test plan
- **Reset:** Reset=1 mid-cycle with PC_RESET=32'h0040_0000 → PC=0x00400000, counters 0, AddrErr 0 immediately. Release, no control instructions → PC increments by 4 per cycle.
- **BEQ taken:** PCPlus4ID=0x100, Imm16=0xFFFE, ZeroFlag=1 → CompCont=001, Flush=1, next PC=0x0F8, one REDIRECT cycle, BranchCount=1, TakenCount=1. Same branch with ZeroFlag=0 → PC+4, BranchCount=2, TakenCount=1.
- **JAL:** JAL at PCPlus4ID=0x1000_0004, JumpTarget=26'h0000010 → CompCont=110, LinkWrite=1, LinkAddr=0x10000004, next PC=0x10000040, counters unchanged.
- **JR unaligned:** JR with RSData=0x0000_2003 → next PC=0x00002000, AddrErr=1 and stays 1 until Reset.
- **Stall during BNE:** Stall=1 for 3 cycles with ZeroFlag=1 → PC held, Flush=0, counters unchanged. Stall drops → redirect taken once, counts increment once.
- **Back-to-back and wrap:**
  - BGTZ taken followed by ValidID=1 BEQ in the next cycle → BEQ ignored (CompCont=111), PC=target+4.
  - Branch at PCPlus4ID=0xFFFF_FFFC, Imm16=0x0001 → target 0x00000000 (wrap).

Source files
------------

// File: rtl/branch_resolve_unit.sv
// ID-stage branch/jump resolver: drives the comparator select and owns the fetch PC.
// Redirects on a taken branch or any jump, with one squashed REDIRECT bubble after it.
module branch_resolve_unit #(
    parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Stall,
    input  logic        ValidID,
    input  logic [5:0]  Opcode,
    input  logic [5:0]  Funct,
    input  logic [4:0]  RtField,
    input  logic [15:0] Imm16,
    input  logic [25:0] JumpTarget,
    input  logic [31:0] PCPlus4ID,
    input  logic [31:0] RSData,
    input  logic        ZeroFlag,
    output logic [2:0]  CompCont,
    output logic [31:0] PC,
    output logic        Flush,
    output logic        LinkWrite,
    output logic [31:0] LinkAddr,
    output logic        AddrErr,
    output logic [31:0] BranchCount,
    output logic [31:0] TakenCount
);

    typedef enum logic {
        RUN,
        REDIRECT
    } state_t;

    state_t      state;
    logic        decodeEn;
    logic        isJump;
    logic        isJal;
    logic        isJr;
    logic        isCond;
    logic        taken;
    logic [31:0] brTarget;
    logic [31:0] jTarget;
    logic [31:0] jrTarget;
    logic [31:0] target;

    // The squashed slot and the reset window both decode as non-control.
    assign decodeEn = !Reset && (state == RUN) && ValidID;

    // Comparator select; jumps use 110 so the comparator answers 1.
    always_comb begin
        CompCont = 3'b111;
        if (decodeEn) begin
            unique case (1'b1)
                (Opcode == 6'b000001 && RtField == 5'b00001): CompCont = 3'b000;
                (Opcode == 6'b000100):                        CompCont = 3'b001;
                (Opcode == 6'b000101):                        CompCont = 3'b010;
                (Opcode == 6'b000111):                        CompCont = 3'b011;
                (Opcode == 6'b000110):                        CompCont = 3'b100;
                (Opcode == 6'b000001 && RtField == 5'b00000): CompCont = 3'b101;
                (Opcode == 6'b000010):                        CompCont = 3'b110;
                (Opcode == 6'b000011):                        CompCont = 3'b110;
                (Opcode == 6'b000000 && Funct == 6'b001000):  CompCont = 3'b110;
                default:                                      CompCont = 3'b111;
            endcase
        end
    end

    assign isJal  = decodeEn && (Opcode == 6'b000011);
    assign isJr   = decodeEn && (Opcode == 6'b000000) && (Funct == 6'b001000);
    assign isJump = (CompCont == 3'b110);
    assign isCond = (CompCont <= 3'b101);

    // A stalled instruction is held and re-resolved later, so nothing fires now.
    assign taken = (CompCont != 3'b111) && ZeroFlag && !Stall;

    assign brTarget = PCPlus4ID + {{14{Imm16[15]}}, Imm16, 2'b00};
    assign jTarget  = {PCPlus4ID[31:28], JumpTarget, 2'b00};
    assign jrTarget = {RSData[31:2], 2'b00};

    // Redirect target selection for the resolved instruction.
    always_comb begin
        target = brTarget;
        if (isJr) begin
            target = jrTarget;
        end else if (isJump) begin
            target = jTarget;
        end
    end

    assign Flush     = taken;
    assign LinkWrite = taken && isJal;
    assign LinkAddr  = isJal ? PCPlus4ID : 32'h0000_0000;

    // PC, redirect state, sticky alignment error and branch statistics.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state       <= RUN;
            PC          <= PC_RESET;
            AddrErr     <= 1'b0;
            BranchCount <= 32'h0000_0000;
            TakenCount  <= 32'h0000_0000;
        end else if (!Stall) begin
            if (taken) begin
                PC    <= target;
                state <= REDIRECT;
            end else begin
                PC    <= PC + 32'd4;
                state <= RUN;
            end
            if (isCond) begin
                BranchCount <= BranchCount + 32'd1;
                if (taken) begin
                    TakenCount <= TakenCount + 32'd1;
                end
            end
            if (taken && isJr && (RSData[1:0] != 2'b00)) begin
                AddrErr <= 1'b1;
            end
        end
    end

endmodule
